fetch_queue_unit: RTL
=====================

// Module: fetch_queue_unit
// PURPOSE
//  Instruction-fetch front end. Generates sequential PCs, issues requests on the instruction-memory
//  req/gnt/rvalid interface and holds returned words in an in-order prefetch queue. Feeds {pc, instr}
//  to the IF/ID pipeline buffer, which samples them while pause is low. Branch/jump redirect flushes the queue.
// PARAMETERS
//  DEPTH     4              queue entries; power of 2, >=2; also the max number of outstanding requests
//  RESET_PC  32'h0000_0000  first fetch address after reset
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  pause        in   1   hazard stall, same signal as the IF/ID buffer pause; 1 = hold the head entry
//  redirect     in   1   branch/jump taken; flush and refetch from redirect_pc
//  redirect_pc  in   32  new fetch address; bits[1:0] ignored (forced 0)
//  imem_req     out  1   request valid
//  imem_addr    out  32  request word address (byte address, 4-aligned)
//  imem_gnt     in   1   request accepted this cycle when imem_req=1
//  imem_rvalid  in   1   read data valid; responses in grant order, >=1 cycle after their grant
//  imem_rdata   in   32  instruction word
//  if_valid     out  1   head entry holds a valid instruction
//  if_pc        out  32  PC of the head entry
//  if_instr     out  32  instruction of the head entry
// BEHAVIOUR
//  Reset (async, reset=0): fetch_pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; if_valid=0; if_pc=0;
//   if_instr=0; queue empty; outstanding=0; drop=0. imem_req may first rise the cycle after reset deasserts.
//  Queue: reservation FIFO. alloc_ptr advances at grant (stores pc), fill_ptr advances at kept rvalid
//   (stores instr), rd_ptr advances at pop. All pointers wrap modulo DEPTH with an extra wrap bit.
//  Issue: imem_req=1 iff allocated entries < DEPTH and drop+outstanding < DEPTH. Stays high with addr held
//   until gnt. At grant: fetch_pc += 4 (32-bit wrap 32'hFFFF_FFFC -> 0); the next request may follow back-to-back.
//  Output: if_valid=1 iff head entry is filled and redirect=0; if_pc/if_instr = head fields (hold last
//   value when if_valid=0). Pop when if_valid=1 && pause=0.
//  Latency: req+gnt in cycle N, rvalid in N+1 -> if_valid in N+2. Sustained 1 instr/cycle with 1-cycle memory.
//  Full queue: imem_req=0 until a pop frees an entry. Pop and grant in the same cycle are both honoured.
//  Redirect (registered effect): in the redirect cycle fetch_pc<=redirect_pc&~3, all pointers reset, and
//   drop<=outstanding (+1 if a grant occurs this cycle, -1 if an rvalid occurs this cycle). imem_req is
//   registered-driven, so a grant in the redirect cycle is counted and dropped. An ungranted pending
//   request is withdrawn next cycle; memory must tolerate abandonment. First request to redirect_pc is issued
//   the next cycle. Responses with drop>0 are discarded and decrement drop.
//  Priority: reset > redirect > pause. Redirect with pause: flush anyway, no pop.
//  Redirect during reset is ignored. Back-to-back redirects: the last one wins, and drop accumulates correctly.
//  Protocol error (rvalid with no outstanding/drop): ignored; assertion in simulation.
// CONFIGURATION
//  FETCH_BYPASS_EN defined: when the head entry is allocated but unfilled and a kept rvalid targets it,
//   if_valid=1 and if_instr=imem_rdata combinationally in the same cycle. If popped that cycle, the entry
//   is freed without being written. Latency is req N -> if_valid N+1.
//  Undefined: instr is always registered into the queue first; latency is N+2. No imem_rdata->if_* path.
// TESTING
//  1 Reset release, 1-cycle memory, gnt always 1 -> addrs 0,4,8..; if_valid from cycle 2 (cycle 1 with
//    FETCH_BYPASS_EN); pc/instr pairs in order.
//  2 pause=1 for 10 cycles at pc=0x10 -> if_pc holds 0x10; 4 entries fill, imem_req=0; after release, 0x10..0x1C
//    are popped consecutively.
//  3 redirect to 0x200 with 3 requests outstanding -> 3 rvalids discarded; next if_pc=0x200; no stale pc is seen.
//  4 redirect same cycle as gnt and rvalid -> drop count correct (gnt counted, rvalid consumed); first valid pc=target.
//  5 Random gnt/rvalid latency 1-5 cycles with random pause -> scoreboard: every pc = previous+4 except after
//    redirect; no loss or duplicates.
//  6 reset asserted mid-burst with rvalid pending -> outputs go to reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end with an in-order prefetch queue.
// Issues sequential word fetches on a req/gnt/rvalid memory port, reserves a queue
// slot at grant and fills it when the response returns. A redirect flushes the
// queue, and responses that are still in flight are then counted off and dropped.
// Optional build macro: FETCH_BYPASS_EN (forward imem_rdata to the head in the same cycle).
module fetch_queue_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pause,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] ONE_P   = PW'(1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW:0]   DEPTH_W = (PW+1)'(DEPTH);

    logic [PW-1:0] r_alloc, r_fill, r_rd, r_drop;
    logic [PW-1:0] w_alloc_n, w_fill_n, w_rd_n, w_drop_n;
    logic [PW-1:0] w_outstanding, w_used_n, w_out_n;
    logic [PW:0]   w_inflight_n;
    logic [31:0]   r_fetch_pc, w_fetch_pc_n;
    logic          r_req, w_req_n;
    logic [31:0]   r_pc_q    [DEPTH];
    logic [31:0]   r_instr_q [DEPTH];
    logic [31:0]   r_hold_pc, r_hold_instr;
    logic          w_gnt, w_rsp, w_kept, w_head_filled, w_bypass, w_pop, w_write;

    assign imem_req  = r_req;
    assign imem_addr = r_fetch_pc;

    assign w_gnt         = r_req & imem_gnt;
    assign w_outstanding = r_alloc - r_fill;
    // A response is legal if it is either owed to the queue or still to be dropped.
    assign w_rsp         = imem_rvalid & ((r_drop != '0) | (w_outstanding != '0));
    assign w_kept        = imem_rvalid & (r_drop == '0) & (w_outstanding != '0);
    assign w_head_filled = (r_rd != r_fill);

`ifdef FETCH_BYPASS_EN
    // A kept response always targets the oldest unfilled slot; if that is the head, forward it.
    assign w_bypass = w_kept & ~w_head_filled;
    assign if_instr = if_valid ? (w_bypass ? imem_rdata : r_instr_q[r_rd[AW-1:0]]) : r_hold_instr;
`else
    assign w_bypass = 1'b0;
    assign if_instr = if_valid ? r_instr_q[r_rd[AW-1:0]] : r_hold_instr;
`endif

    assign if_valid = (w_head_filled | w_bypass) & ~redirect;
    assign if_pc    = if_valid ? r_pc_q[r_rd[AW-1:0]] : r_hold_pc;
    assign w_pop    = if_valid & ~pause;
    // A bypassed entry that is popped at once never needs its storage written.
    assign w_write  = w_kept & ~redirect & ~(w_bypass & w_pop);

    // Next-state for pointers, drop count, fetch PC and the registered request.
    always_comb begin
        w_alloc_n    = r_alloc;
        w_fill_n     = r_fill;
        w_rd_n       = r_rd;
        w_drop_n     = r_drop;
        w_fetch_pc_n = r_fetch_pc;
        if (redirect) begin
            w_alloc_n    = '0;
            w_fill_n     = '0;
            w_rd_n       = '0;
            w_drop_n     = r_drop + w_outstanding + PW'(w_gnt) - PW'(w_rsp);
            w_fetch_pc_n = redirect_pc & ~32'h3;
        end else begin
            if (w_gnt) begin
                w_alloc_n    = r_alloc + ONE_P;
                w_fetch_pc_n = r_fetch_pc + 32'd4;
            end
            if (w_kept) begin
                w_fill_n = r_fill + ONE_P;
            end else if (imem_rvalid && (r_drop != '0)) begin
                w_drop_n = r_drop - ONE_P;
            end
            if (w_pop) begin
                w_rd_n = r_rd + ONE_P;
            end
        end
        w_used_n     = w_alloc_n - w_rd_n;
        w_out_n      = w_alloc_n - w_fill_n;
        w_inflight_n = {1'b0, w_drop_n} + {1'b0, w_out_n};
        w_req_n      = (w_used_n < DEPTH_P) && (w_inflight_n < DEPTH_W);
    end

    // Control state: pointers, drop count, fetch PC, request and last-shown head fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alloc      <= '0;
            r_fill       <= '0;
            r_rd         <= '0;
            r_drop       <= '0;
            r_fetch_pc   <= RESET_PC;
            r_req        <= 1'b0;
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
        end else begin
            r_alloc    <= w_alloc_n;
            r_fill     <= w_fill_n;
            r_rd       <= w_rd_n;
            r_drop     <= w_drop_n;
            r_fetch_pc <= w_fetch_pc_n;
            r_req      <= w_req_n;
            if (if_valid) begin
                r_hold_pc    <= if_pc;
                r_hold_instr <= if_instr;
            end
        end
    end

    // Queue payload storage: pc written at grant, instruction at kept response.
    always_ff @(posedge clk) begin
        if (w_gnt && !redirect) begin
            r_pc_q[r_alloc[AW-1:0]] <= r_fetch_pc;
        end
        if (w_write) begin
            r_instr_q[r_fill[AW-1:0]] <= imem_rdata;
        end
    end

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!reset)
        imem_rvalid |-> ((r_drop != '0) || (w_outstanding != '0)));

endmodule
